universal_shift_reg: RTL
========================

// Module: universal_shift_reg
// PURPOSE
//  Parametrised universal shift register: shifts or rotates left/right by STEP
//  bits, parallel load, set-all-ones and clear modes, all from one register.
//  A frame counter pulses frame_done after FRAME_LEN shift/rotate operations,
//  so serialiser/deserialiser front-ends can frame words without extra logic.
//  Sits between serial links and word-wide datapaths.
// PARAMETERS
//  WIDTH      8            register width in bits; WIDTH >= 2
//  STEP       1            bits moved per shift/rotate; 1 <= STEP < WIDTH
//  FRAME_LEN  WIDTH/STEP   shift/rotate ops per frame; >= 1
// PORTS
//  clk           in   1          rising-edge clock, single clock domain
//  reset         in   1          synchronous, active-high reset
//  enable        in   1          1 = perform mode this cycle; 0 = hold all state
//  mode          in   3          operation select (see BEHAVIOUR)
//  ser_in_lsb    in   STEP       bits entering at LSB end on SHL
//  ser_in_msb    in   STEP       bits entering at MSB end on SHR
//  parallel_in   in   WIDTH      word captured on LOAD
//  data_out      out  WIDTH      register contents
//  ser_out_msb   out  STEP       data_out[WIDTH-1 -: STEP], combinational from reg
//  ser_out_lsb   out  STEP       data_out[STEP-1:0], combinational from reg
//  shift_count   out  CW         ops completed in current frame, CW=$clog2(FRAME_LEN+1)
//  frame_done    out  1          one-cycle pulse: frame completed
// BEHAVIOUR
//  - Reset (sampled at posedge clk): data_out=0, shift_count=0, frame_done=0.
//    Reset overrides enable and mode; reset mid-frame discards the partial frame.
//  - Priority: reset > enable==0 > mode. enable==0: data_out, shift_count hold;
//    frame_done=0.
//  - mode (enable==1), result visible one cycle after the sampling edge:
//    000 HOLD   data_out unchanged, count unchanged
//    001 SHL    {data_out[WIDTH-STEP-1:0], ser_in_lsb}
//    010 SHR    {ser_in_msb, data_out[WIDTH-1:STEP]}
//    011 ROL    {data_out[WIDTH-STEP-1:0], data_out[WIDTH-1 -: STEP]}
//    100 ROR    {data_out[STEP-1:0], data_out[WIDTH-1:STEP]}
//    101 LOAD   parallel_in
//    110 SET1   all ones
//    111 CLEAR  all zeros
//  - Counter: SHL/SHR/ROL/ROR increment shift_count. When shift_count==FRAME_LEN-1
//    and such an op executes, shift_count wraps to 0 and frame_done=1 next cycle.
//    FRAME_LEN==1: every shift/rotate pulses frame_done.
//  - LOAD/SET1/CLEAR set shift_count=0 and frame_done=0 (frame restarts).
//  - HOLD: frame_done=0; count unchanged.
//  - frame_done is registered and never asserts two cycles running unless
//    FRAME_LEN==1 and shifts are back-to-back.
//  - Direction changes mid-frame are allowed; they all count toward the frame.
//  - Serial inputs are ignored in every mode except their own shift mode.
// STRUCTURE
//  - Package shift_reg_pkg: mode encodings MODE_HOLD..MODE_CLEAR as 3-bit
//    localparams, plus a function is_shift_op(mode).
//  - Sub-module frame_counter (FRAME_LEN, CW): inc, clr -> count, done pulse.
//    Data register and mode mux stay in the top module.
//  - Elaboration check: STEP < WIDTH, FRAME_LEN >= 1; otherwise $error.
// TESTING  (WIDTH=8, STEP=1, FRAME_LEN=8 unless noted)
//  1 reset=1 two cycles, any mode/enable -> data_out=00, shift_count=0, frame_done=0
//  2 LOAD A5, then SHL ser_in_lsb=1 -> 4B; SHR ser_in_msb=0 -> 25;
//    ROL on 81 -> 03; ROR on 81 -> C0
//  3 CLEAR, then 8 consecutive SHL with ser_in_lsb=1 -> data_out=FF,
//    frame_done=1 exactly once (cycle after 8th shift), shift_count back to 0
//  4 5 shifts, LOAD 3C -> count=0, no frame_done; 8 more shifts -> one pulse
//  5 enable=0 for 3 cycles mid-frame with mode=SHL -> data_out, count frozen,
//    frame_done=0; resume -> frame completes after remaining shifts
//  6 STEP=2, WIDTH=8, FRAME_LEN=4: LOAD 00, SHL ser_in_lsb=2'b11 x4 -> FF, pulse
//    after 4th op; reset asserted at op 2 of a frame -> all outputs 0 next cycle

Source files
------------

// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - mode encodings and mode classification helpers for universal_shift_reg
package shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHL   = 3'b001;
  localparam logic [2:0] MODE_SHR   = 3'b010;
  localparam logic [2:0] MODE_ROL   = 3'b011;
  localparam logic [2:0] MODE_ROR   = 3'b100;
  localparam logic [2:0] MODE_LOAD  = 3'b101;
  localparam logic [2:0] MODE_SET1  = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  // Shifts and rotates advance the frame counter.
  function automatic logic is_shift_op(input logic [2:0] mode);
    return (mode == MODE_SHL) || (mode == MODE_SHR) ||
           (mode == MODE_ROL) || (mode == MODE_ROR);
  endfunction

  // Whole-word writes restart the frame.
  function automatic logic is_restart_op(input logic [2:0] mode);
    return (mode == MODE_LOAD) || (mode == MODE_SET1) || (mode == MODE_CLEAR);
  endfunction

endpackage

// File: rtl/universal_shift_reg_frame_counter.sv
// rtl/universal_shift_reg_frame_counter.sv - counts shift ops per frame, pulses done on wrap
module frame_counter #(
  parameter int FRAME_LEN = 8,
  parameter int CW        = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [CW-1:0] count_o,
  output logic          done_o
);

  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;

  // done is only ever a single-cycle echo of the wrapping increment.
  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      if (count_q == LAST) begin
        count_d = '0;
        done_d  = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = done_q;

endmodule

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - universal shift/rotate/load register with frame counter
module universal_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STEP      = 1,
  parameter int FRAME_LEN = WIDTH / STEP
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [2:0]                       mode,
  input  logic [STEP-1:0]                  ser_in_lsb,
  input  logic [STEP-1:0]                  ser_in_msb,
  input  logic [WIDTH-1:0]                 parallel_in,
  output logic [WIDTH-1:0]                 data_out,
  output logic [STEP-1:0]                  ser_out_msb,
  output logic [STEP-1:0]                  ser_out_lsb,
  output logic [$clog2(FRAME_LEN+1)-1:0]   shift_count,
  output logic                             frame_done
);

  localparam int CW = $clog2(FRAME_LEN + 1);

  if (WIDTH < 2 || STEP < 1 || STEP >= WIDTH || FRAME_LEN < 1) begin : g_param_check
    $error("universal_shift_reg: need WIDTH>=2, 1<=STEP<WIDTH, FRAME_LEN>=1");
  end

  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (enable) begin
      case (mode)
        MODE_SHL:   data_d = {data_q[WIDTH-STEP-1:0], ser_in_lsb};
        MODE_SHR:   data_d = {ser_in_msb, data_q[WIDTH-1:STEP]};
        MODE_ROL:   data_d = {data_q[WIDTH-STEP-1:0], data_q[WIDTH-1 -: STEP]};
        MODE_ROR:   data_d = {data_q[STEP-1:0], data_q[WIDTH-1:STEP]};
        MODE_LOAD:  data_d = parallel_in;
        MODE_SET1:  data_d = '1;
        MODE_CLEAR: data_d = '0;
        default:    data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  frame_counter #(
    .FRAME_LEN (FRAME_LEN),
    .CW        (CW)
  ) u_frame_counter (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (enable && is_shift_op(mode)),
    .clr_i   (enable && is_restart_op(mode)),
    .count_o (shift_count),
    .done_o  (frame_done)
  );

  assign data_out    = data_q;
  assign ser_out_msb = data_q[WIDTH-1 -: STEP];
  assign ser_out_lsb = data_q[STEP-1:0];

endmodule
